// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared edge codes, FSM state type and sprite defaults for the enemy blocks
package enemy_pkg;

    typedef logic [3:0] edge_t;

    localparam edge_t EDGE_NONE   = 4'b0000;
    localparam edge_t EDGE_LEFT   = 4'b1000;
    localparam edge_t EDGE_TOP    = 4'b0100;
    localparam edge_t EDGE_RIGHT  = 4'b0010;
    localparam edge_t EDGE_BOTTOM = 4'b0001;

    localparam int DEF_OBJ_W = 32;
    localparam int DEF_OBJ_H = 32;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_RESOLVE,
        ST_REPORT,
        ST_WAIT
    } hit_state_t;

    // Counter scan order is B, T, R, L so that strict ">" gives the tie priority.
    function automatic edge_t scan_edge(input logic [1:0] idx);
        case (idx)
            2'd0:    return EDGE_BOTTOM;
            2'd1:    return EDGE_TOP;
            2'd2:    return EDGE_RIGHT;
            default: return EDGE_LEFT;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advances when step is high
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (step) begin
            state <= {feedback, state[15:1]};
        end
    end

endmodule

// File: rtl/enemy_hit_detector.sv
// rtl/enemy_hit_detector.sv - per-frame enemy/obstacle edge hit classifier with collision pulse
// Macro ENEMY_HIT_LFSR_EN selects an LFSR random bit; otherwise random toggles every frame.
module enemy_hit_detector
    import enemy_pkg::*;
#(
    parameter int          OBJ_W       = DEF_OBJ_W,
    parameter int          OBJ_H       = DEF_OBJ_H,
    parameter int          EDGE_W      = 4,
    parameter int          REPORT_LINE = 470,
    parameter int          REPORT_COL  = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               enemyDR,
    input  logic               obstacleDR,
    output logic               collision,
    output edge_t              HitEdgeCode,
    output logic               random
);

    localparam logic signed [10:0] BAND   = 11'(EDGE_W);
    localparam logic signed [10:0] RIGHT0 = 11'(OBJ_W - EDGE_W);
    localparam logic signed [10:0] BOT0   = 11'(OBJ_H - EDGE_W);

    hit_state_t        state;
    logic [1:0]        idx;
    edge_t             best;
    logic [7:0]        best_cnt;
    logic [7:0]        cnt [4];

    logic signed [10:0] off_x;
    logic signed [10:0] off_y;
    logic               hit;
    logic               trigger;
    logic [3:0]         band;
    logic               cand_gt;
    logic [7:0]         cand_cnt;
    edge_t              cand_edge;

    assign off_x = $signed(pixelX) - topLeftX;
    assign off_y = $signed(pixelY) - topLeftY;
    assign hit   = enemyDR && obstacleDR && (state == ST_COLLECT);
    assign trigger = (pixelY == 11'(REPORT_LINE)) && (pixelX == 11'(REPORT_COL));

    // Bands indexed in scan order; negative offsets belong to no band.
    assign band[0] = off_y >= BOT0;
    assign band[1] = !off_y[10] && (off_y < BAND);
    assign band[2] = off_x >= RIGHT0;
    assign band[3] = !off_x[10] && (off_x < BAND);

    assign cand_gt   = cnt[idx] > best_cnt;
    assign cand_cnt  = cand_gt ? cnt[idx] : best_cnt;
    assign cand_edge = cand_gt ? scan_edge(idx) : best;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_COLLECT;
            idx         <= 2'd0;
            best        <= EDGE_NONE;
            best_cnt    <= 8'd0;
            collision   <= 1'b0;
            HitEdgeCode <= EDGE_NONE;
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        end else if (startOfFrame) begin
            state     <= ST_COLLECT;
            idx       <= 2'd0;
            collision <= 1'b0;
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        end else begin
            collision <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (hit) begin
                        for (int i = 0; i < 4; i++) begin
                            if (band[i]) cnt[i] <= sat_inc(cnt[i]);
                        end
                    end
                    if (trigger) begin
                        state    <= ST_RESOLVE;
                        idx      <= 2'd0;
                        best     <= EDGE_NONE;
                        best_cnt <= 8'd0;
                    end
                end
                ST_RESOLVE: begin
                    best     <= cand_edge;
                    best_cnt <= cand_cnt;
                    idx      <= idx + 2'd1;
                    // Outputs are registered on the last compare so they are valid during REPORT.
                    if (idx == 2'd3) begin
                        state       <= ST_REPORT;
                        collision   <= (cand_cnt != 8'd0);
                        HitEdgeCode <= (cand_cnt != 8'd0) ? cand_edge : EDGE_NONE;
                    end
                end
                ST_REPORT: state <= ST_WAIT;
                default:   state <= ST_WAIT;
            endcase
        end
    end

`ifdef ENEMY_HIT_LFSR_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (reset),
        .step  (startOfFrame),
        .state (lfsr_state)
    );

    assign unused_lfsr = ^{lfsr_state[15:2], lfsr_state[0]};

    // Bit 1 of the current state becomes bit 0 after this step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random <= 1'b0;
        end else if (startOfFrame) begin
            random <= lfsr_state[1];
        end
    end
`else
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random <= 1'b0;
        end else if (startOfFrame) begin
            random <= ~random;
        end
    end
`endif

endmodule

// File: tb/tb_enemy_hit_detector.sv
// tb/tb_enemy_hit_detector.sv - self-checking bench for enemy_hit_detector
module tb_enemy_hit_detector;

    localparam int OBJ = 32;
    localparam int EW  = 4;
    localparam int TX  = 100;
    localparam int TY  = 200;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sof = 1'b0;
    logic [10:0]        px = '0;
    logic [10:0]        py = '0;
    logic signed [10:0] tlx = 11'sd100;
    logic signed [10:0] tly = 11'sd200;
    logic               edr = 1'b0;
    logic               odr = 1'b0;
    logic               collision, random;
    logic [3:0]         HitEdgeCode;
    logic               coll2, rnd2;
    logic [3:0]         code2;

    int n_checks = 0;
    int n_errors = 0;
    logic run_cmp = 1'b0;

    always #5 clk = ~clk;

    enemy_hit_detector dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .topLeftX(tlx), .topLeftY(tly), .enemyDR(edr), .obstacleDR(odr),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .random(random)
    );

    enemy_hit_detector #(.EDGE_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .topLeftX(tlx), .topLeftY(tly), .enemyDR(edr), .obstacleDR(odr),
        .collision(coll2), .HitEdgeCode(code2), .random(rnd2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (counts kept in L,T,R,B order) ----------------
    int         m_cnt [4];
    logic       m_collect;
    int         m_report_at;
    int         edge_no;
    logic       m_coll;
    logic [3:0] m_code;
    logic       m_rand;
    logic [15:0] m_lfsr;

    function automatic int off(input logic [10:0] p, input logic signed [10:0] t);
        return int'(p) - int'(t);
    endfunction

    function automatic int bump(input int v, input logic inc);
        return (inc && v < 255) ? v + 1 : v;
    endfunction

    function automatic logic [3:0] winner(input int l, input int t, input int r, input int b);
        int mx;
        mx = l;
        if (t > mx) mx = t;
        if (r > mx) mx = r;
        if (b > mx) mx = b;
        if (mx == 0) return 4'b0000;
        if (b == mx) return 4'b0001;
        if (t == mx) return 4'b0100;
        if (r == mx) return 4'b0010;
        return 4'b1000;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic lfsr_low(input logic [15:0] s);
        logic [15:0] n;
        n = lfsr_next(s);
        return n[0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
            m_collect   <= 1'b1;
            m_report_at <= -1;
            edge_no     <= 0;
            m_coll      <= 1'b0;
            m_code      <= 4'b0000;
            m_rand      <= 1'b0;
            m_lfsr      <= 16'hACE1;
        end else begin
            edge_no <= edge_no + 1;
            m_coll  <= 1'b0;
            if (sof) begin
                for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
                m_collect   <= 1'b1;
                m_report_at <= -1;
`ifdef ENEMY_HIT_LFSR_EN
                m_lfsr <= lfsr_next(m_lfsr);
                m_rand <= lfsr_low(m_lfsr);
`else
                m_rand <= ~m_rand;
`endif
            end else begin
                if (m_collect) begin
                    m_cnt[0] <= bump(m_cnt[0], edr && odr && off(px, tlx) >= 0 && off(px, tlx) < EW);
                    m_cnt[1] <= bump(m_cnt[1], edr && odr && off(py, tly) >= 0 && off(py, tly) < EW);
                    m_cnt[2] <= bump(m_cnt[2], edr && odr && off(px, tlx) >= OBJ - EW);
                    m_cnt[3] <= bump(m_cnt[3], edr && odr && off(py, tly) >= OBJ - EW);
                    if (int'(py) == 470 && int'(px) == 0) begin
                        m_collect   <= 1'b0;
                        m_report_at <= edge_no + 4;
                    end
                end
                if (edge_no == m_report_at) begin
                    m_code <= winner(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
                    m_coll <= winner(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]) != 4'b0000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            check("cyc_collision", int'(collision), int'(m_coll));
            check("cyc_code", int'(HitEdgeCode), int'(m_code));
            check("cyc_random", int'(random), int'(m_rand));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input int x, input int y, input logic e, input logic o);
        @(negedge clk);
        sof = s;
        px  = 11'(x);
        py  = 11'(y);
        edr = e;
        odr = o;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = TY - 1; y <= TY + OBJ; y++) begin
            for (int x = TX - 1; x <= TX + OBJ; x++) begin
                drive(1'b0, x, y, (x >= TX && x < TX + OBJ && y >= TY && y < TY + OBJ),
                      (x >= x0 && x <= x1 && y >= y0 && y <= y1));
            end
        end
    endtask

    task automatic new_frame(input int x0, input int x1, input int y0, input int y1);
        drive(1'b1, 600, 0, 1'b0, 1'b0);
        scan(x0, x1, y0, y1);
    endtask

    task automatic run_trigger(input int sof_at, input int rst_at,
                               output int p1, output int k1, output int p2);
        p1 = 0;
        k1 = -1;
        p2 = 0;
        drive(1'b0, 0, 470, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive(k == sof_at, 1, 470, 1'b0, 1'b0);
            if (k == rst_at + 1) reset = 1'b0;
            if (collision) begin
                p1++;
                k1 = k;
            end
            if (coll2) p2++;
            if (k == rst_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_collision", int'(collision), 0);
                check("rst_code", int'(HitEdgeCode), 0);
                check("rst_random", int'(random), 0);
            end
        end
    endtask

    int p1, k1, p2;
    int exp_rand [5];

    initial begin
`ifdef ENEMY_HIT_LFSR_EN
        exp_rand = '{0, 0, 0, 0, 1};
`else
        exp_rand = '{1, 0, 1, 0, 1};
`endif
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("init_collision", int'(collision), 0);
        check("init_code", int'(HitEdgeCode), 0);
        check("init_random", int'(random), 0);
        reset = 1'b0;
        run_cmp = 1'b1;

        // Right-edge hit
        new_frame(128, 131, 200, 231);
        run_trigger(0, 0, p1, k1, p2);
        check("right_pulses", p1, 1);
        check("right_pulse_cycle", k1, 5);
        check("right_code", int'(HitEdgeCode), 4'b0010);
        check("right_model_R", m_cnt[2], 128);
        check("right_model_T", m_cnt[1], 16);
        check("right_model_B", m_cnt[3], 16);
        check("right_dut_R", int'(dut.cnt[2]), 128);
        check("right_dut_T", int'(dut.cnt[1]), 16);
        check("right_dut_B", int'(dut.cnt[0]), 16);
        check("right_dut_L", int'(dut.cnt[3]), 0);

        // No overlap
        new_frame(1, 0, 1, 0);
        run_trigger(0, 0, p1, k1, p2);
        check("none_pulses", p1, 0);
        check("none_code", int'(HitEdgeCode), 0);

        // Corner tie: TOP beats LEFT
        new_frame(100, 103, 200, 203);
        run_trigger(0, 0, p1, k1, p2);
        check("tie_pulses", p1, 1);
        check("tie_code", int'(HitEdgeCode), 4'b0100);

        // Saturation on the 8-pixel-band instance
        new_frame(100, 107, 200, 231);
        run_trigger(0, 0, p1, k1, p2);
        check("sat_code", int'(HitEdgeCode), 4'b1000);
        check("sat8_pulses", p2, 1);
        check("sat8_code", int'(code2), 4'b1000);
        check("sat8_cntL", int'(u_dut8.cnt[3]), 255);
        check("sat8_cntT", int'(u_dut8.cnt[1]), 64);

        // Abort with startOfFrame at T+2
        new_frame(128, 131, 200, 231);
        run_trigger(2, 0, p1, k1, p2);
        check("abort_pulses", p1, 0);
        check("abort_code_held", int'(HitEdgeCode), 4'b1000);
        check("abort_cnt_clear", int'(dut.cnt[0]) + int'(dut.cnt[1]) + int'(dut.cnt[2]) + int'(dut.cnt[3]), 0);

        // startOfFrame on the trigger pixel: clear wins, collection continues
        scan(128, 131, 200, 231);
        drive(1'b1, 0, 470, 1'b0, 1'b0);
        scan(128, 131, 200, 231);
        run_trigger(0, 0, p1, k1, p2);
        check("sof_trig_pulses", p1, 1);
        check("sof_trig_code", int'(HitEdgeCode), 4'b0010);

        // Reset at T+3
        new_frame(128, 131, 200, 231);
        run_trigger(0, 3, p1, k1, p2);
        check("reset_pulses", p1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 600, 0, 1'b0, 1'b0);
            drive(1'b0, 600, 1, 1'b0, 1'b0);
            check($sformatf("rand_seq%0d", i), int'(random), exp_rand[i]);
        end
        repeat (2) drive(1'b0, 600, 2, 1'b0, 1'b0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
